// File: rtl/pause_sync_if.sv
// Pause-sync signal bundle between the pause/video/bus side and the CPU clock-enable gate.
// The master drives requests and raw enables; the slave (pause_sync) returns the gated enable and halt status.
interface pause_sync_if;
    logic pause_cpu;
    logic step;
    logic vblank;
    logic bus_idle;
    logic ce_in;
    logic ce_out;
    logic paused;

    modport master (
        output pause_cpu,
        output step,
        output vblank,
        output bus_idle,
        output ce_in,
        input  ce_out,
        input  paused
    );

    modport slave (
        input  pause_cpu,
        input  step,
        input  vblank,
        input  bus_idle,
        input  ce_in,
        output ce_out,
        output paused
    );
endinterface

// File: rtl/pause_sync.sv
// Aligns a pause request to a vblank rising edge and a CPU bus-idle point before gating the CPU
// clock enable, and supports single-frame stepping while halted.
module pause_sync #(
    parameter int unsigned CLKSPD      = 12,
    parameter int unsigned WDOG_CYCLES = CLKSPD * 20000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    pause_sync_if.slave ps
);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_WAIT_VB   = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_HALT      = 3'd3,
        ST_STEP      = 3'd4
    } state_t;

    localparam logic [31:0] WDOG_MAX = 32'(WDOG_CYCLES - 32'd1);

    state_t      state_r;
    logic        vblank_d_r;
    logic        step_d_r;
    logic [31:0] wdog_r;
    logic        paused_r;

    logic        vb_edge_s;
    logic        step_edge_s;
    logic        wdog_done_s;
    logic        ce_out_s;

    assign vb_edge_s   = ps.vblank & ~vblank_d_r;
    assign step_edge_s = ps.step & ~step_d_r;
    assign wdog_done_s = (wdog_r == WDOG_MAX);

    // Frame/bus-aligned pause state machine; paused_r mirrors "state is HALT" with no extra lag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_RUN;
            vblank_d_r <= 1'b0;
            step_d_r   <= 1'b0;
            wdog_r     <= 32'd0;
            paused_r   <= 1'b0;
        end else begin
            vblank_d_r <= ps.vblank;
            step_d_r   <= ps.step;
            paused_r   <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    wdog_r <= 32'd0;
                    if (ps.pause_cpu) begin
                        state_r <= ST_WAIT_VB;
                    end
                end
                ST_WAIT_VB, ST_STEP: begin
                    // Saturate instead of wrapping so a missing vblank always ends in a forced boundary.
                    if (!wdog_done_s) begin
                        wdog_r <= wdog_r + 32'd1;
                    end
                    if (!ps.pause_cpu) begin
                        state_r <= ST_RUN;
                    end else if (vb_edge_s || wdog_done_s) begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!ps.pause_cpu) begin
                        state_r <= ST_RUN;
                    end else if (ps.bus_idle) begin
                        state_r  <= ST_HALT;
                        paused_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!ps.pause_cpu) begin
                        state_r <= ST_RUN;
                    end else if (step_edge_s) begin
                        state_r <= ST_STEP;
                        wdog_r  <= 32'd0;
                    end else begin
                        paused_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Enable gate: withheld as soon as the bus is idle at the boundary so no cycle is torn.
    always_comb begin
        ce_out_s = ps.ce_in;
        case (state_r)
            ST_RUN:       ce_out_s = ps.ce_in;
            ST_WAIT_VB:   ce_out_s = ps.ce_in;
            ST_STEP:      ce_out_s = ps.ce_in;
            ST_WAIT_IDLE: ce_out_s = ps.ce_in & ~ps.bus_idle;
            ST_HALT:      ce_out_s = 1'b0;
            default:      ce_out_s = ps.ce_in;
        endcase
    end

    assign ps.ce_out = ce_out_s;
    assign ps.paused = paused_r;

endmodule
